// File: rtl/inst_fetcher_pkg.sv
// Shared types and constants for the serial instruction fetcher.
// Fetch-FSM state encoding, default reset PC and the word-alignment helper.
package inst_fetcher_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'b00,
        S_WAIT = 2'b01,
        S_HOLD = 2'b10,
        S_DROP = 2'b11
    } if_state_e;

    // Fetch addresses are always word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetcher.sv
// Serial instruction fetcher: one outstanding icache request, presents each word to the
// decoder until it issues, and handles ROB redirects including stale in-flight responses.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        wrong_predicted,
    input  logic [31:0] correct_pc,
    input  logic [31:0] next_pc,
    input  logic        jalr_stall,
    input  logic        issue_signal,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_gnt,
    input  logic        icache_resp_valid,
    input  logic [31:0] icache_inst,
    output logic        valid,
    output logic        start_decoder,
    output logic [31:0] inst_addr,
    output logic [31:0] inst,
    output logic [31:0] fetch_cnt
);

    if_state_e   state;
    logic [31:0] pc;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= S_REQ;
            pc        <= align_pc(RESET_PC);
            inst      <= 32'h0;
            inst_addr <= 32'h0;
            fetch_cnt <= 32'h0;
        end else if (rdy_in) begin
            unique case (state)
                S_REQ: begin
                    if (wrong_predicted) begin
                        pc <= align_pc(correct_pc);
                        // A grant in the redirect cycle leaves a stale response to absorb.
                        if (icache_gnt) state <= S_DROP;
                    end else if (icache_gnt) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wrong_predicted) begin
                        pc    <= align_pc(correct_pc);
                        state <= icache_resp_valid ? S_REQ : S_DROP;
                    end else if (icache_resp_valid) begin
                        inst      <= icache_inst;
                        inst_addr <= pc;
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Redirect wins over a simultaneous issue; the flushed word is not counted.
                    if (wrong_predicted) begin
                        pc    <= align_pc(correct_pc);
                        state <= S_REQ;
                    end else if (issue_signal && !jalr_stall) begin
                        pc        <= align_pc(next_pc);
                        fetch_cnt <= fetch_cnt + 32'd1;
                        state     <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (wrong_predicted) pc <= align_pc(correct_pc);
                    if (icache_resp_valid) state <= S_REQ;
                end
            endcase
        end
    end

    // Request is suppressed while reset is held so nothing goes out before release.
    assign icache_req    = (state == S_REQ) && !rst_in;
    assign icache_addr   = pc;
    assign valid         = (state == S_HOLD);
    assign start_decoder = (state == S_HOLD) && rdy_in;

endmodule
